// File: rtl/fnd_scan_mux.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : fnd_scan_mux                                             |
// | Description : Time-multiplexed scanner for a multi-digit 7-segment     |
// |               (FND) display. A prescaler sets how long each digit is   |
// |               driven. On every digit advance the next digit index, its |
// |               BCD code and the active-low common enables are           |
// |               registered together, so they always change on the same  |
// |               clock edge.                                              |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
// | Parameters                                                             |
// |   DIGITS      number of 4-bit BCD digits scanned (2..16)               |
// |   CLK_DIV     clk cycles each digit is driven (>= 1)                   |
// | Ports                                                                  |
// |   clk         system clock, rising edge                                |
// |   reset       synchronous active-high reset                            |
// |   en          scan enable; low freezes prescaler, sel and outputs      |
// |   digits_in   packed BCD, digit i at [4i+3:4i], digit 0 = LSD          |
// |   blank_mask  bit i high forces digit i dark                           |
// |   sel         index of the digit currently driven                      |
// |   bcd         BCD code of the current digit, 4'hF when dark            |
// |   digit_com   active-low common enables, at most one bit low           |
// |   scan_tick   one-cycle pulse on every digit advance                   |
// |   frame_start one-cycle pulse when sel advances to 0                   |
// | Build option                                                           |
// |   FND_LEADING_ZERO_BLANK_EN  when defined, leading zero digits above   |
// |                              digit 0 are also darkened                 |
// +------------------------------------------------------------------------+

module fnd_scan_mux #(
  parameter  int DIGITS  = 8,
  parameter  int CLK_DIV = 100000,
  localparam int SEL_W   = $clog2(DIGITS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [4*DIGITS-1:0] digits_in,
  input  logic [DIGITS-1:0]   blank_mask,
  output logic [SEL_W-1:0]    sel,
  output logic [3:0]          bcd,
  output logic [DIGITS-1:0]   digit_com,
  output logic                scan_tick,
  output logic                frame_start
);

  // Prescaler needs at least one bit even when every cycle is an advance.
  localparam int               PS_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PS_W-1:0]  C_PS_MAX   = PS_W'(CLK_DIV - 1);
  localparam logic [SEL_W-1:0] C_SEL_MAX  = SEL_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] C_COM_ONE = DIGITS'(1);

  // Registered state
  logic [PS_W-1:0]   ps_q,    ps_d;
  logic [SEL_W-1:0]  sel_q,   sel_d;
  logic [3:0]        bcd_q,   bcd_d;
  logic [DIGITS-1:0] com_q,   com_d;
  logic              tick_q,  tick_d;
  logic              frame_q, frame_d;

  // Combinational helpers
  logic [3:0]        w_digit [DIGITS];
  logic [DIGITS-1:0] w_lz_dark;
  logic              w_zero_run;
  logic              w_tick;
  logic [SEL_W-1:0]  w_sel_next;
  logic              w_dark;

  // Unpack the flat BCD bus into one nibble per digit.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_unpack
      assign w_digit[gi] = digits_in[4*gi +: 4];
    end
  endgenerate

`ifdef FND_LEADING_ZERO_BLANK_EN
  // Walk down from the most significant digit; a digit is a leading zero
  // while every digit from it upward is zero. Digit 0 is always shown so a
  // value of zero still displays a single "0".
  always_comb begin
    w_lz_dark  = '0;
    w_zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero_run   = w_zero_run && (w_digit[i] == 4'h0);
      w_lz_dark[i] = w_zero_run;
    end
  end
`else
  // Zeros are displayed; only blank_mask darkens digits.
  always_comb begin
    w_lz_dark  = '0;
    w_zero_run = 1'b0;
  end
`endif

  always_comb begin
    w_tick     = en && (ps_q == C_PS_MAX);
    w_sel_next = (sel_q == C_SEL_MAX) ? '0 : sel_q + 1'b1;
    w_dark     = blank_mask[w_sel_next] | w_lz_dark[w_sel_next];

    ps_d    = ps_q;
    sel_d   = sel_q;
    bcd_d   = bcd_q;
    com_d   = com_q;
    tick_d  = 1'b0;
    frame_d = 1'b0;

    if (en) begin
      ps_d = w_tick ? '0 : ps_q + 1'b1;
    end

    // Inputs are sampled only here, so the displayed digit cannot change
    // mid-dwell even if digits_in or blank_mask do.
    if (w_tick) begin
      sel_d   = w_sel_next;
      tick_d  = 1'b1;
      frame_d = (w_sel_next == '0);
      if (w_dark) begin
        bcd_d = 4'hF;
        com_d = '1;
      end else begin
        bcd_d = w_digit[w_sel_next];
        com_d = ~(C_COM_ONE << w_sel_next);
      end
    end
  end

  // sel parks at the last digit so the first advance lands on digit 0 and
  // raises frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q    <= '0;
      sel_q   <= C_SEL_MAX;
      bcd_q   <= 4'hF;
      com_q   <= '1;
      tick_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      ps_q    <= ps_d;
      sel_q   <= sel_d;
      bcd_q   <= bcd_d;
      com_q   <= com_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
    end
  end

  assign sel         = sel_q;
  assign bcd         = bcd_q;
  assign digit_com   = com_q;
  assign scan_tick   = tick_q;
  assign frame_start = frame_q;

endmodule

`default_nettype wire
